// File: rtl/herring_clkgen_if.sv
// Purpose : bundles the clock generator's decoder-facing signals (stretch request in, PHI2/reset out).
// Latency : none; plain wires between the clock generator and the address decoder.
// Backpressure: none; slow_n is a level request that is sampled once per PHI2 low phase.
//
// Signals:
//   slow_n     decoder -> clkgen  active-low slow-device select (combinational in the decoder)
//   stretch_en decoder -> clkgen  global enable for high-phase stretching
//   phi2       clkgen  -> decoder registered CPU clock
//   res_n      clkgen  -> decoder registered active-low CPU reset
//   phi2_rise  clkgen  -> decoder one-cycle pulse in the first clk_src cycle of each high phase
//   stretching clkgen  -> decoder high while the high phase is being extended
interface herring_clkgen_if;
  logic slow_n;
  logic stretch_en;
  logic phi2;
  logic res_n;
  logic phi2_rise;
  logic stretching;

  // master: the clock generator itself
  modport master (
    input  slow_n,
    input  stretch_en,
    output phi2,
    output res_n,
    output phi2_rise,
    output stretching
  );

  // slave: the address decoder that consumes PHI2 and feeds back slow_n
  modport slave (
    output slow_n,
    output stretch_en,
    input  phi2,
    input  res_n,
    input  phi2_rise,
    input  stretching
  );
endinterface

// File: rtl/herring_clkgen.sv
// Purpose : 6502 PHI2 generator and CPU reset sequencer with slow-device high-phase stretching.
// Latency : all outputs are registered; they change on the clk_src edge that changes the state.
// Backpressure: none; a slow device lengthens one PHI2 high phase instead of stalling a handshake.
//
// Ports:
//   clk_src  50 MHz oscillator, the only clock
//   reset    asynchronous active-high reset
//   bus      herring_clkgen_if.master: slow_n/stretch_en in, phi2/res_n/phi2_rise/stretching out
module herring_clkgen #(
  parameter int LOW_CYCLES     = 25,
  parameter int HIGH_CYCLES    = 25,
  parameter int STRETCH_CYCLES = 50,
  parameter int RES_CYCLES     = 8
) (
  input  logic             clk_src,
  input  logic             reset,
  herring_clkgen_if.master bus
);

  localparam int MAX_LH = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int MAXC   = (MAX_LH > STRETCH_CYCLES) ? MAX_LH : STRETCH_CYCLES;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW     = (RES_CYCLES > 0) ? $clog2(RES_CYCLES + 1) : 1;

  localparam logic [CW-1:0] LOW_LAST     = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST    = CW'(HIGH_CYCLES - 1);
  // With stretching disabled HIGH_EXT is unreachable; keep the constant in range anyway.
  localparam logic [CW-1:0] STRETCH_LAST = CW'((STRETCH_CYCLES > 0) ? STRETCH_CYCLES - 1 : 0);
  localparam logic [PW-1:0] RES_LAST     = PW'(RES_CYCLES - 1);
  localparam logic [PW-1:0] RES_FULL     = PW'(RES_CYCLES);
  localparam logic          STRETCH_OK   = (STRETCH_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_HIGH     = 2'd1,
    ST_HIGH_EXT = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pcnt_q;
  logic          slow_q;
  logic          phi2_q;
  logic          res_n_q;
  logic          rise_q;
  logic          stretching_q;
  logic          fall_d;

  // A PHI2 falling edge happens on this clock edge: end of an unstretched high
  // phase, or end of the extension.
  always_comb begin
    fall_d = 1'b0;
    if (state_q == ST_HIGH && cnt_q == HIGH_LAST && !slow_q) begin
      fall_d = 1'b1;
    end
    if (state_q == ST_HIGH_EXT && cnt_q == STRETCH_LAST) begin
      fall_d = 1'b1;
    end
  end

  always_ff @(posedge clk_src or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOW;
      cnt_q        <= '0;
      pcnt_q       <= '0;
      slow_q       <= 1'b0;
      phi2_q       <= 1'b0;
      res_n_q      <= 1'b0;
      rise_q       <= 1'b0;
      stretching_q <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      case (state_q)
        ST_LOW: begin
          if (cnt_q == LOW_LAST) begin
            // The only point where slow_n is looked at; it decides the high
            // phase that starts on this very edge.
            slow_q  <= ~bus.slow_n & bus.stretch_en & STRETCH_OK;
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            phi2_q  <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            cnt_q <= '0;
            if (slow_q) begin
              state_q      <= ST_HIGH_EXT;
              stretching_q <= 1'b1;
            end else begin
              state_q <= ST_LOW;
              phi2_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_HIGH_EXT: begin
          if (cnt_q == STRETCH_LAST) begin
            state_q      <= ST_LOW;
            cnt_q        <= '0;
            phi2_q       <= 1'b0;
            stretching_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q      <= ST_LOW;
          cnt_q        <= '0;
          phi2_q       <= 1'b0;
          stretching_q <= 1'b0;
        end
      endcase

      // CPU reset hold: count PHI2 falls while res_n is low; release on the
      // RES_CYCLES-th fall. The counter never moves past RES_CYCLES.
      if (fall_d && !res_n_q) begin
        if (pcnt_q != RES_FULL) begin
          pcnt_q <= pcnt_q + PW'(1);
        end
        if (pcnt_q == RES_LAST) begin
          res_n_q <= 1'b1;
        end
      end
    end
  end

  assign bus.phi2       = phi2_q;
  assign bus.res_n      = res_n_q;
  assign bus.phi2_rise  = rise_q;
  assign bus.stretching = stretching_q;

endmodule

// File: tb/tb_herring_clkgen.sv
// Purpose : self-checking bench for herring_clkgen (default build plus a minimum-parameter build).
// Latency : outputs sampled on the falling clk_src edge, half a cycle after each active edge.
// Backpressure: n/a; stimulus toggles slow_n/stretch_en between active edges.
module tb_herring_clkgen;

  localparam int LO = 25;
  localparam int HI = 25;
  localparam int ST = 50;
  localparam int RC = 8;

  logic clk_src = 1'b0;
  logic reset;

  always #5 clk_src = ~clk_src;

  herring_clkgen_if bus_a ();
  herring_clkgen_if bus_b ();

  herring_clkgen u_dut_a (
    .clk_src (clk_src),
    .reset   (reset),
    .bus     (bus_a.master)
  );

  herring_clkgen #(
    .LOW_CYCLES     (2),
    .HIGH_CYCLES    (2),
    .STRETCH_CYCLES (0),
    .RES_CYCLES     (1)
  ) u_dut_b (
    .clk_src (clk_src),
    .reset   (reset),
    .bus     (bus_b.master)
  );

  int n_chk;
  int n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model for the default build: a queue of expected per-cycle
  // {phi2, phi2_rise, stretching}, refilled one whole phase at a time.
  logic [2:0] mq[$];
  logic       last_high;
  int         falls;
  int         k;          // clk_src edges since reset release
  int         first_rise, first_fall, res_rise, rise_cnt;
  logic [2:0] expv;

  task automatic model_init();
    mq.delete();
    // The cycle right after release is already low-phase cycle 1.
    repeat (LO - 1) mq.push_back(3'b000);
    last_high  = 1'b0;
    falls      = 0;
    k          = 0;
    first_rise = -1;
    first_fall = -1;
    res_rise   = -1;
    rise_cnt   = 0;
  endtask

  task automatic model_edge();
    logic stretch;
    if (mq.size() == 0) begin
      if (last_high) begin
        repeat (LO) mq.push_back(3'b000);
        falls++;
        last_high = 1'b0;
      end else begin
        stretch = !bus_a.slow_n && bus_a.stretch_en && (ST != 0);
        mq.push_back(3'b110);
        repeat (HI - 1) mq.push_back(3'b100);
        if (stretch) repeat (ST) mq.push_back(3'b101);
        last_high = 1'b1;
      end
    end
    expv = mq.pop_front();
  endtask

  // One clk_src cycle: advance model on the rising edge, compare on the falling edge.
  task automatic step();
    @(posedge clk_src);
    k++;
    model_edge();
    @(negedge clk_src);
    check("a_phi2",       bus_a.phi2,       expv[2]);
    check("a_phi2_rise",  bus_a.phi2_rise,  expv[1]);
    check("a_stretching", bus_a.stretching, expv[0]);
    check("a_res_n",      bus_a.res_n,      (falls >= RC));
    // Minimum build: 4-cycle period, high on edges 2,3 mod 4, released at first fall.
    check("b_phi2",       bus_b.phi2,       ((k % 4) >= 2));
    check("b_phi2_rise",  bus_b.phi2_rise,  ((k % 4) == 2));
    check("b_stretching", bus_b.stretching, 1'b0);
    check("b_res_n",      bus_b.res_n,      (k >= 4));
    if (bus_a.phi2_rise) begin
      if (k <= 500) rise_cnt++;
      if (first_rise < 0) first_rise = k;
    end
    if (first_fall < 0 && first_rise >= 0 && !bus_a.phi2) first_fall = k;
    if (res_rise < 0 && bus_a.res_n) res_rise = k;
  endtask

  task automatic wait_a_phi2(input logic v);
    int n;
    n = 0;
    while (bus_a.phi2 !== v && n < 300) begin
      step();
      n++;
    end
    if (bus_a.phi2 !== v) check("wait_phi2_tmo", bus_a.phi2, v);
  endtask

  // Called in high-phase cycle 1; returns in the first low cycle.
  task automatic measure_high(output int hl, output int sc, output int fs);
    int n;
    hl = 1; sc = 0; fs = -1; n = 0;
    while (bus_a.phi2 === 1'b1 && n < 300) begin
      step();
      n++;
      if (bus_a.phi2 === 1'b1) begin
        hl++;
        if (bus_a.stretching === 1'b1) begin
          sc++;
          if (fs < 0) fs = hl;
        end
      end
    end
  endtask

  task automatic measure_low(output int ll);
    int n;
    ll = 1; n = 0;
    while (bus_a.phi2 === 1'b0 && n < 300) begin
      step();
      n++;
      if (bus_a.phi2 === 1'b0) ll++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_src);
    reset = 1'b1;
    repeat (3) @(negedge clk_src);
    check("rst_a_phi2",  bus_a.phi2,       1'b0);
    check("rst_a_res_n", bus_a.res_n,      1'b0);
    check("rst_a_rise",  bus_a.phi2_rise,  1'b0);
    check("rst_a_str",   bus_a.stretching, 1'b0);
    check("rst_b_phi2",  bus_b.phi2,       1'b0);
    check("rst_b_res_n", bus_b.res_n,      1'b0);
    reset = 1'b0;
    model_init();
  endtask

  initial begin
    int hl, sc, fs, ll;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    bus_a.slow_n = 1'b1;
    bus_a.stretch_en = 1'b1;
    bus_b.slow_n = 1'b0;      // minimum build never stretches even with a slow select
    bus_b.stretch_en = 1'b1;
    model_init();

    // Nominal clock and CPU reset release, then 20+ periods with res_n held high.
    do_reset();
    repeat (1450) step();
    check("first_rise", first_rise, 25);
    check("first_fall", first_fall, 50);
    check("rise_cnt10", rise_cnt, 10);
    check("res_rise",   res_rise, 400);

    // Stretch: slow_n low across the last low cycle.
    wait_a_phi2(1);
    wait_a_phi2(0);
    bus_a.slow_n = 1'b0;
    wait_a_phi2(1);
    bus_a.slow_n = 1'b1;
    measure_high(hl, sc, fs);
    check("str_high_len", hl, 75);
    check("str_ext_len",  sc, 50);
    check("str_ext_first", fs, 26);
    measure_low(ll);
    measure_high(hl, sc, fs);
    check("period_after_str", ll + hl, 50);

    // slow_n low only during a high phase: no effect on this or the next high phase.
    wait_a_phi2(1);
    bus_a.slow_n = 1'b0;
    measure_high(hl, sc, fs);
    bus_a.slow_n = 1'b1;
    check("ign_high_len", hl, 25);
    wait_a_phi2(1);
    measure_high(hl, sc, fs);
    check("ign_next_len", hl, 25);
    check("ign_next_str", sc, 0);

    // slow_n low at the sample edge but stretching globally disabled.
    bus_a.stretch_en = 1'b0;
    bus_a.slow_n = 1'b0;
    wait_a_phi2(1);
    bus_a.slow_n = 1'b1;
    bus_a.stretch_en = 1'b1;
    measure_high(hl, sc, fs);
    check("dis_high_len", hl, 25);
    check("dis_str",      sc, 0);

    // Asynchronous reset at high-phase cycle 10 of a stretched cycle.
    wait_a_phi2(0);
    bus_a.slow_n = 1'b0;
    wait_a_phi2(1);
    bus_a.slow_n = 1'b1;
    repeat (9) step();
    check("mid_res_before", bus_a.res_n, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_a_phi2",  bus_a.phi2,       1'b0);
    check("mid_a_str",   bus_a.stretching, 1'b0);
    check("mid_a_res_n", bus_a.res_n,      1'b0);
    check("mid_a_rise",  bus_a.phi2_rise,  1'b0);
    check("mid_b_phi2",  bus_b.phi2,       1'b0);
    @(negedge clk_src);
    reset = 1'b0;
    model_init();
    repeat (450) step();
    check("mid_first_rise", first_rise, 25);
    check("mid_res_rise",   res_rise, 400);

    // Randomized slow_n / stretch_en against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 3) == 0) bus_a.slow_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) bus_a.stretch_en = ~bus_a.stretch_en;
      bus_b.slow_n = 1'($urandom_range(0, 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

endmodule
